sobel_edge: RTL and testbench
=============================

SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 IMG_W, 640, pixels per line; valid range 4..2048.
REQ-002 IMG_H, 480, lines per frame; valid range 4..2048.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 din  input  8  grayscale pixel, raster order, from the smoothing stage.
REQ-006 din_en  input  1  din valid this cycle; gaps of any length are allowed.
REQ-007 frame_start  input  1  qualifies the din_en beat that carries pixel (0,0); ignored when din_en=0.
REQ-008 threshold  input  8  binarisation threshold, sampled per frame.
REQ-009 dout_mag  output  8  saturated gradient magnitude.
REQ-010 dout_bin  output  8  binary edge map: 8'hFF = edge, 8'h00 = none.
REQ-011 dout_en  output  1  dout_mag/dout_bin valid this cycle.

Function
REQ-012 Column counter col (0..IMG_W-1) SHALL advance on each accepted beat and wrap to 0; row counter row SHALL advance on the wrap, and wrap from IMG_H-1 to 0.
REQ-013 A beat with frame_start=1 SHALL be treated as (0,0), and counters SHALL continue from there, including mid-frame.
REQ-014 Two IMG_W-deep line buffers SHALL hold rows row-1 and row-2, written and read at address col only on accepted beats.
REQ-015 A 3x3 window p[i][j] SHALL shift only on accepted beats: i=0 is row-2, i=2 is the current row; j=0 is col-2, j=2 is the current column.
REQ-016 Gx = (p02+2*p12+p22) - (p00+2*p10+p20); Gy = (p20+2*p21+p22) - (p00+2*p01+p02); both signed 11-bit, computed with no overflow.
REQ-017 mag = |Gx|+|Gy|, unsigned 12-bit, max 2040.
REQ-018 dout_mag SHALL be min(mag,255).
REQ-019 dout_bin SHALL be 8'hFF iff mag > thr_q (strict), else 8'h00.
REQ-020 When the input beat has row<2 or col<2, the window is incomplete: dout_mag and dout_bin SHALL be forced to 0.
REQ-021 Output raster position (r,c) SHALL carry the result centred on input pixel (r-1,c-1), i.e. a one-pixel shift; the output count SHALL equal the input count.
REQ-022 thr_q SHALL load threshold on the beat with frame_start=1 and stay constant otherwise.
REQ-023 The pipeline SHALL have 3 stages (window/read, Gx/Gy, abs-sum/saturate/compare), each tracked by its own valid bit.
REQ-024 dout_en SHALL pulse exactly 3 clk after each accepted beat, one pulse per beat; gaps in din_en SHALL pass through unchanged.
REQ-025 There is no back-pressure: the downstream stage SHALL take every dout_en beat.
REQ-026 dout_mag/dout_bin SHALL hold their last value while dout_en=0.

Reset
REQ-027 On rst_n=0, dout_mag, dout_bin, dout_en, all valid bits, col, row and window registers SHALL clear to 0, and thr_q SHALL set to 8'd64.
REQ-028 Line-buffer contents SHALL NOT be reset; REQ-020 masks stale data.
REQ-029 Reset asserted mid-frame SHALL drop all in-flight beats with no dout_en afterwards; the next frame SHALL begin with frame_start.

Verification
REQ-030 The bench SHALL cover: IMG_W=8, IMG_H=4, uniform din=100, threshold=10 -> 32 dout_en pulses; all dout_mag=0, dout_bin=00.
REQ-031 The bench SHALL cover: IMG_W=8, IMG_H=4, columns 0-3 =0, columns 4-7 =200, threshold=64 -> rows 2-3, output cols 4-5 (centres 3,4): Gx=800, dout_mag=255, dout_bin=FF; other outputs 0.
REQ-032 The bench SHALL cover: a window with mag exactly 64 and threshold=64 -> dout_bin=00; the same window with threshold=63 -> dout_bin=FF.
REQ-033 The bench SHALL cover: random 0-5 cycle gaps on din_en -> each dout_en exactly 3 clk after its beat; results bit-identical to the gapless run.
REQ-034 The bench SHALL cover: frame_start at input (2,5), then a full frame -> counters restart, the first two new rows output 0, and thr_q takes the new threshold.
REQ-035 The bench SHALL cover: rst_n pulsed low with 2 beats in flight -> no dout_en afterwards; outputs 0; thr_q=64.

Source files
------------

// File: rtl/sobel_edge_if.sv
// Pixel stream interface for the Sobel edge stage.
//   din / din_en / frame_start / threshold : upstream -> edge detector
//   dout_mag / dout_bin / dout_en          : edge detector -> downstream
// master: the side that feeds pixels and consumes results (upstream/downstream pair).
// slave : the edge detector itself.
interface sobel_edge_if;
    logic [7:0] din;
    logic       din_en;
    logic       frame_start;
    logic [7:0] threshold;
    logic [7:0] dout_mag;
    logic [7:0] dout_bin;
    logic       dout_en;

    modport master (
        output din, din_en, frame_start, threshold,
        input  dout_mag, dout_bin, dout_en
    );

    modport slave (
        input  din, din_en, frame_start, threshold,
        output dout_mag, dout_bin, dout_en
    );
endinterface

// File: rtl/sobel_edge.sv
// 3x3 Sobel gradient magnitude and binary edge map on a raster pixel stream.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : sobel_edge_if.slave -- din/din_en/frame_start/threshold in,
//            dout_mag/dout_bin/dout_en out (3 cycles after each accepted beat)
// Output (r,c) carries the result centred on input pixel (r-1,c-1); beats whose
// window is incomplete (row<2 or col<2) produce zero.
module sobel_edge #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480
) (
    input logic         clk,
    input logic         rst_n,
    sobel_edge_if.slave bus
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
    localparam logic [7:0]    ThrReset = 8'd64;

    logic accept;
    assign accept = bus.din_en;

    // ------------------------------------------------------------------
    // Raster position and per-frame threshold
    // ------------------------------------------------------------------
    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic [7:0]    thr_q, thr_d;

    always_comb begin
        // frame_start re-anchors the current beat at (0,0), even mid-frame
        cur_col = bus.frame_start ? '0 : col_q;
        cur_row = bus.frame_start ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        thr_d   = thr_q;
        if (accept) begin
            if (bus.frame_start) begin
                thr_d = bus.threshold;
            end
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            thr_q <= ThrReset;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            thr_q <= thr_d;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb1 holds row-1, lb0 holds row-2. Not reset; stale
    // contents only ever reach masked windows.
    // ------------------------------------------------------------------
    logic [7:0] lb0_mem [IMG_W];
    logic [7:0] lb1_mem [IMG_W];
    logic [7:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0_mem[cur_col];
    assign lb1_rd = lb1_mem[cur_col];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0_mem[cur_col] <= lb1_rd;
            lb1_mem[cur_col] <= bus.din;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: 3x3 window. win_q[i][j]: i=0 row-2 .. i=2 current row,
    // j=0 col-2 .. j=2 current column.
    // ------------------------------------------------------------------
    logic [2:0][2:0][7:0] win_q;
    logic                 v1_q;
    logic                 mask1_q;
    logic [7:0]           thr1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= '0;
            v1_q    <= 1'b0;
            mask1_q <= 1'b0;
            thr1_q  <= ThrReset;
        end else begin
            v1_q <= accept;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb0_rd;
                win_q[1][2] <= lb1_rd;
                win_q[2][2] <= bus.din;
                mask1_q     <= (cur_row < RW'(2)) || (cur_col < CW'(2));
                // Threshold travels with the beat so a new frame cannot
                // re-grade pixels of the previous one still in flight.
                thr1_q      <= thr_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: Gx / Gy, signed 11-bit (|G| <= 1020, no overflow)
    // ------------------------------------------------------------------
    function automatic logic signed [10:0] px1(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    function automatic logic signed [10:0] px2(input logic [7:0] p);
        return $signed({2'b00, p, 1'b0});
    endfunction

    logic signed [10:0] gx_d, gy_d, gx_q, gy_q;
    logic               v2_q;
    logic               mask2_q;
    logic [7:0]         thr2_q;

    always_comb begin
        gx_d = (px1(win_q[0][2]) + px2(win_q[1][2]) + px1(win_q[2][2]))
             - (px1(win_q[0][0]) + px2(win_q[1][0]) + px1(win_q[2][0]));
        gy_d = (px1(win_q[2][0]) + px2(win_q[2][1]) + px1(win_q[2][2]))
             - (px1(win_q[0][0]) + px2(win_q[0][1]) + px1(win_q[0][2]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q    <= '0;
            gy_q    <= '0;
            v2_q    <= 1'b0;
            mask2_q <= 1'b0;
            thr2_q  <= ThrReset;
        end else begin
            v2_q <= v1_q;
            if (v1_q) begin
                gx_q    <= gx_d;
                gy_q    <= gy_d;
                mask2_q <= mask1_q;
                thr2_q  <= thr1_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: |Gx|+|Gy|, saturate, threshold compare
    // ------------------------------------------------------------------
    logic [10:0] ax, ay;
    logic [11:0] mag;
    logic [7:0]  mag_sat;
    logic [7:0]  dout_mag_d, dout_bin_d;
    logic [7:0]  dout_mag_q, dout_bin_q;
    logic        dout_en_q;

    always_comb begin
        ax         = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        ay         = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag        = 12'(ax) + 12'(ay);
        mag_sat    = (mag > 12'd255) ? 8'hFF : mag[7:0];
        dout_mag_d = mask2_q ? 8'h00 : mag_sat;
        dout_bin_d = (!mask2_q && (mag > {4'b0000, thr2_q})) ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_mag_q <= '0;
            dout_bin_q <= '0;
            dout_en_q  <= 1'b0;
        end else begin
            dout_en_q <= v2_q;
            if (v2_q) begin
                dout_mag_q <= dout_mag_d;
                dout_bin_q <= dout_bin_d;
            end
        end
    end

    assign bus.dout_mag = dout_mag_q;
    assign bus.dout_bin = dout_bin_q;
    assign bus.dout_en  = dout_en_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed self-checking bench for sobel_edge on an 8x4 image.
module tb_sobel_edge;

    localparam int W    = 8;
    localparam int H    = 4;
    localparam int NPIX = W * H;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sobel_edge_if bus ();

    sobel_edge #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         in_cyc_q[$];
    int         out_cyc_q[$];
    logic [7:0] out_mag_q[$];
    logic [7:0] out_bin_q[$];

    always @(negedge clk) begin
        if (bus.dout_en === 1'b1) begin
            out_cyc_q.push_back(cyc);
            out_mag_q.push_back(bus.dout_mag);
            out_bin_q.push_back(bus.dout_bin);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        in_cyc_q.delete();
        out_cyc_q.delete();
        out_mag_q.delete();
        out_bin_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            bus.din_en      = 1'b0;
            bus.frame_start = 1'b0;
        end
    endtask

    task automatic drive_beat(input logic [7:0] pix, input logic fs, input logic [7:0] thr);
        @(posedge clk);
        #1;
        bus.din         = pix;
        bus.din_en      = 1'b1;
        bus.frame_start = fs;
        bus.threshold   = thr;
        in_cyc_q.push_back(cyc);
    endtask

    // 0: flat 100, 1: step 0|200 at col 4, 2: step 0|16, 3: step 0|17, 4: flat 50
    function automatic logic [7:0] img_pix(input int kind, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c >= 4) ? 8'd200 : 8'd0;
            2:       return (c >= 4) ? 8'd16 : 8'd0;
            3:       return (c >= 4) ? 8'd17 : 8'd0;
            4:       return 8'd50;
            default: return 8'd0;
        endcase
    endfunction

    task automatic send_beats(input int kind, input int n, input logic fs, input logic [7:0] thr,
                              input int max_gap);
        for (int k = 0; k < n; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            drive_beat(img_pix(kind, k % W), fs && (k == 0), thr);
        end
    endtask

    // Step images give a nonzero result only at output rows 2-3, cols 4-5
    // (centres on columns 3 and 4, straddling the step); all else is 0.
    task automatic check_frame(input string tag, input logic [7:0] e_mag, input logic [7:0] e_bin);
        check_eq({tag, " count"}, out_mag_q.size(), NPIX);
        for (int k = 0; k < NPIX; k++) begin
            if (k < out_mag_q.size() && k < in_cyc_q.size()) begin
                int  r;
                int  c;
                bit  hit;
                r   = k / W;
                c   = k % W;
                hit = (r >= 2) && (c == 4 || c == 5);
                check_eq($sformatf("%s mag[%0d]", tag, k), out_mag_q[k], hit ? e_mag : 8'h00);
                check_eq($sformatf("%s bin[%0d]", tag, k), out_bin_q[k], hit ? e_bin : 8'h00);
                check_eq($sformatf("%s lat[%0d]", tag, k), out_cyc_q[k] - in_cyc_q[k], 3);
            end
        end
    endtask

    task automatic run_frame(input string tag, input int kind, input logic fs, input logic [7:0] thr,
                             input int max_gap, input logic [7:0] e_mag, input logic [7:0] e_bin);
        clear_q();
        send_beats(kind, NPIX, fs, thr, max_gap);
        idle(6);
        check_frame(tag, e_mag, e_bin);
    endtask

    initial begin
        bus.din         = '0;
        bus.din_en      = 1'b0;
        bus.frame_start = 1'b0;
        bus.threshold   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset dout_en", bus.dout_en, 1'b0);
        check_eq("reset dout_mag", bus.dout_mag, 8'h00);
        check_eq("reset dout_bin", bus.dout_bin, 8'h00);
        rst_n = 1'b1;
        idle(2);

        // Flat image: no gradient anywhere
        run_frame("flat", 0, 1'b1, 8'd10, 0, 8'h00, 8'h00);
        // Vertical step 0|200: Gx = 4*200 = 800, saturates
        run_frame("step", 1, 1'b1, 8'd64, 0, 8'hFF, 8'hFF);
        // Step 0|16: mag exactly 64; strict compare
        run_frame("thr64", 2, 1'b1, 8'd64, 0, 8'd64, 8'h00);
        run_frame("thr63", 2, 1'b1, 8'd63, 0, 8'd64, 8'hFF);
        // Same step image with random input gaps
        run_frame("gaps", 1, 1'b1, 8'd64, 5, 8'hFF, 8'hFF);

        // frame_start lands on what would be input (2,5) of a running frame
        clear_q();
        send_beats(4, 21, 1'b1, 8'd64, 0);
        idle(6);
        run_frame("restart", 2, 1'b1, 8'd63, 0, 8'd64, 8'hFF);

        // Reset with two beats in flight; beat (2,4) leaves 255/FF held first
        clear_q();
        send_beats(1, 21, 1'b1, 8'd64, 0);
        idle(6);
        check_eq("hold dout_mag", bus.dout_mag, 8'hFF);
        check_eq("hold dout_bin", bus.dout_bin, 8'hFF);
        clear_q();
        drive_beat(8'd200, 1'b0, 8'd64);
        drive_beat(8'd200, 1'b0, 8'd64);
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        bus.din_en = 1'b0;
        #1;
        check_eq("rst dout_en", bus.dout_en, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(10);
        check_eq("rst no pulses", out_mag_q.size(), 0);
        check_eq("rst dout_mag", bus.dout_mag, 8'h00);
        check_eq("rst dout_bin", bus.dout_bin, 8'h00);

        // No frame_start after reset: threshold input 0 must be ignored, thr stays 64
        run_frame("rst thr m64", 2, 1'b0, 8'd0, 0, 8'd64, 8'h00);
        run_frame("rst thr m68", 3, 1'b0, 8'd0, 0, 8'd68, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
